// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit.
// Multiply uses radix-2 Booth, 32 iterations. Divide uses restoring division
// on operand magnitudes, 32 iterations, followed by a sign-fix cycle.
//
// state | meaning
// IDLE  | waiting for start; captures operands on an accepted start
// MULT  | one Booth iteration per cycle
// DIV   | one restoring-division quotient bit per cycle
// FIX   | applies quotient/remainder signs, loads hi/lo
// DONE  | done pulse, results visible, returns to IDLE
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic        div_0,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    // acc: Booth partial product (33b, sign-extended) or division remainder
    logic [32:0] acc_q, acc_d;
    // q: Booth multiplier shift register or dividend/quotient shift register
    logic [31:0] q_q, q_d;
    // m: sign-extended multiplicand or zero-extended divisor magnitude
    logic [32:0] m_q, m_d;
    logic        qm1_q, qm1_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        div0_q, div0_d;

    logic [32:0] booth_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    // State and datapath registers, all cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            qm1_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            m_q     <= m_d;
            qm1_q   <= qm1_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div0_q  <= div0_d;
        end
    end

    // Next-state logic and iteration datapath
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        q_d     = q_q;
        m_d     = m_q;
        qm1_d   = qm1_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div0_d  = div0_q;

        // 33-bit accumulator keeps +2^31 (from subtracting -2^31) representable
        case ({q_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + m_q;
            2'b10:   booth_sum = acc_q - m_q;
            default: booth_sum = acc_q;
        endcase

        // Remainder stays below the divisor, so the 32-bit slice never truncates
        div_shift = {acc_q[31:0], q_q[31]};
        div_ge    = (div_shift >= m_q);
        div_diff  = div_shift - m_q;
        div_rem   = div_ge ? div_diff[31:0] : div_shift[31:0];

        // 0x80000000 negates to itself, which is its correct unsigned magnitude
        a_mag = A[31] ? (~A + 32'd1) : A;
        b_mag = B[31] ? (~B + 32'd1) : B;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d   = A[31];
                    sb_d   = B[31];
                    cnt_d  = 6'd32;
                    div0_d = op && (B == 32'd0);
                    acc_d  = '0;
                    qm1_d  = 1'b0;
                    if (!op) begin
                        q_d     = B;
                        m_d     = {A[31], A};
                        state_d = S_MULT;
                    end else if (B != 32'd0) begin
                        q_d     = a_mag;
                        m_d     = {1'b0, b_mag};
                        state_d = S_DIV;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_MULT: begin
                acc_d = {booth_sum[32], booth_sum[32:1]};
                q_d   = {booth_sum[0], q_q[31:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    hi_d    = booth_sum[32:1];
                    lo_d    = {booth_sum[0], q_q[31:1]};
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                acc_d = {1'b0, div_rem};
                q_d   = {q_q[30:0], div_ge};
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                lo_d    = (sa_q ^ sb_q) ? (~q_q + 32'd1) : q_q;
                hi_d    = sa_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign div_0 = div0_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        div_0;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .div_0 (div_0),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge. Start is accepted on the next rising edge (cycle N);
    // k counts falling edges after that, so k=1 samples cycle N+1.
    task automatic run_op(input string tag, input logic op_v, input logic [31:0] a_v,
                          input logic [31:0] b_v, input int exp_lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_div0, input bit pulse_mid, input bit start_at_done);
        int k;
        int busy_bad;
        op    = op_v;
        A     = a_v;
        B     = b_v;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        k        = 0;
        busy_bad = 0;
        do begin
            @(negedge clk);
            k++;
            if (busy !== 1'b1) busy_bad++;
            if (pulse_mid && k == 10) begin
                start = 1'b1;
                op    = ~op_v;
                A     = 32'd999;
                B     = 32'd0;
                @(posedge clk);
                #1 start = 1'b0;
            end
        end while (done !== 1'b1 && k < 60);
        chk({tag, ".done"}, {63'd0, done}, 64'd1);
        chk({tag, ".latency"}, 64'(k), 64'(exp_lat));
        chk({tag, ".busy_during"}, 64'(busy_bad), 64'd0);
        chk({tag, ".hi"}, {32'd0, hi}, {32'd0, exp_hi});
        chk({tag, ".lo"}, {32'd0, lo}, {32'd0, exp_lo});
        chk({tag, ".div_0"}, {63'd0, div_0}, {63'd0, exp_div0});
        if (start_at_done) begin
            start = 1'b1;
            op    = 1'b0;
            A     = 32'd1;
            B     = 32'd1;
        end
        @(negedge clk);
        chk({tag, ".done_after"}, {63'd0, done}, 64'd0);
        chk({tag, ".busy_after"}, {63'd0, busy}, 64'd0);
        chk({tag, ".hi_hold"}, {32'd0, hi}, {32'd0, exp_hi});
        chk({tag, ".lo_hold"}, {32'd0, lo}, {32'd0, exp_lo});
        start = 1'b0;
        if (start_at_done) begin
            @(negedge clk);
            chk({tag, ".start_at_done_ignored"}, {63'd0, busy}, 64'd0);
        end
    endtask

    initial begin
        int seen;
        reset = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        A     = '0;
        B     = '0;
        #12;
        chk("reset.busy", {63'd0, busy}, 64'd0);
        chk("reset.done", {63'd0, done}, 64'd0);
        chk("reset.div_0", {63'd0, div_0}, 64'd0);
        chk("reset.hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        @(negedge clk);
        run_op("mult_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 33,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 34,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        run_op("div_5_0", 1'b1, 32'd5, 32'd0, 1,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        run_op("mult_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 33,
               32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34,
               32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        run_op("mult_pulse", 1'b0, 32'd123456, 32'hFFFF_FCEB, 33,
               32'hFFFF_FFFF, 32'hFA31_B0C0, 1'b0, 1'b1, 1'b0);

        // Reset at cycle N+15 of a divide
        @(negedge clk);
        op    = 1'b1;
        A     = 32'd1000;
        B     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 15; k++) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort.busy", {63'd0, busy}, 64'd0);
        chk("abort.done", {63'd0, done}, 64'd0);
        chk("abort.div_0", {63'd0, div_0}, 64'd0);
        chk("abort.hilo", {hi, lo}, 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        seen  = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk("abort.no_done", 64'(seen), 64'd0);
        chk("abort.hilo_idle", {hi, lo}, 64'd0);

        // First rising edge after release accepts start
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run_op("mult_after_reset", 1'b0, 32'd5, 32'd6, 33,
               32'h0000_0000, 32'd30, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL expose these ports, one per line:
- clk  input  1  sole clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  request from the control unit, sampled only in IDLE
- op  input  1  0 = signed multiply (MULT), 1 = signed divide (DIV)
- A  input  32  multiplicand / dividend, captured on accepted start
- B  input  32  multiplier / divisor, captured on accepted start
- busy  output  1  high from the cycle after an accepted start through the DONE cycle
- done  output  1  single-cycle completion pulse
- div_0  output  1  divide-by-zero flag for the last operation
- hi  output  32  product[63:32] or remainder
- lo  output  32  product[31:0] or quotient
REQ-002 The clock and reset SHALL be named clk and reset; reset SHALL be asynchronous and active-low (reset=0 resets).

Function
REQ-003 The block SHALL implement the FSM states IDLE, MULT, DIV, FIX, DONE.
REQ-004 In IDLE with start=1, the block SHALL capture A, B and op, load a 6-bit iteration counter with 32, and clear div_0.
REQ-005 On an accepted start with op=0, the FSM SHALL go to MULT; with op=1 and B!=0, to DIV; with op=1 and B==0, directly to DONE.
REQ-006 MULT SHALL perform radix-2 Booth signed multiplication, one iteration per cycle for 32 cycles, then go to DONE.
REQ-007 DIV SHALL perform restoring division on operand magnitudes, one quotient bit per cycle for 32 cycles, then go to FIX.
REQ-008 FIX SHALL apply signs in one cycle and then go to DONE:
- quotient is negated when sign(A)!=sign(B);
- remainder takes the sign of A.
REQ-009 Latency SHALL be measured from an accepted start in cycle N:
- MULT: done=1 in cycle N+33.
- DIV with B!=0: done=1 in cycle N+34.
- DIV with B==0: done=1 in cycle N+1.
REQ-010 In DONE, the block SHALL assert done for exactly one cycle, drive the final hi/lo values, and return to IDLE on the next edge.
REQ-011 hi, lo and div_0 SHALL hold their values from DONE until the next DONE or reset.
REQ-012 Divide by zero SHALL set div_0=1 in the DONE cycle and SHALL leave hi and lo unchanged.
REQ-013 start SHALL be ignored while busy=1; operands and op SHALL NOT change during an operation.
REQ-014 start asserted in the same cycle as done SHALL be ignored; a new operation SHALL be accepted no earlier than the following IDLE cycle.
REQ-015 Multiply SHALL produce the exact 64-bit two's-complement product, including the case A=B=0x80000000 (result 0x4000000000000000).
REQ-016 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0, with no flag raised.
REQ-017 The block SHALL have no overflow output; division results wrap modulo 2^32.
REQ-018 busy SHALL be 0 in IDLE and 1 in MULT, DIV, FIX and DONE.

Reset
REQ-019 reset=0 SHALL asynchronously force:
- state to IDLE;
- busy=0, done=0, div_0=0;
- hi=0, lo=0;
- counter and all internal operand/accumulator registers to 0.
REQ-020 Reset asserted mid-operation SHALL abort the operation, with no done pulse, and leave all outputs at their reset values.
REQ-021 After reset is released, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- MULT A=7, B=-3 -> in cycle N+33, done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB, div_0=0.
- DIV A=-7, B=2 -> in cycle N+34, done=1, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV A=5, B=0 after the previous test -> in cycle N+1, done=1, div_0=1, hi/lo still 0xFFFFFFFF/0xFFFFFFFD.
- MULT A=B=0x80000000 -> hi=0x40000000, lo=0.
- DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- start pulsed at cycle N+10 during a MULT -> ignored; result and timing unchanged.
- reset=0 at cycle N+15 of a DIV -> busy=0, hi=lo=0, and no done pulse ever appears for that DIV.
REQ-023 Every scenario SHALL check that done is high for exactly one cycle and that busy=0 in the cycle after done.
